// File: rtl/kgp_boot_pkg.sv
// Shared types and constants for the IMEM boot loader slice.
package kgp_boot_pkg;

    typedef enum logic [2:0] {
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERROR
    } boot_state_t;

    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned BYTE_BITS  = 8;
    localparam int unsigned WORD_BITS  = WORD_BYTES * BYTE_BITS;

endpackage

// File: rtl/imem_boot_loader_word_packer.sv
// Packs an MSB-first byte stream into words; word_valid pulses the cycle after the last byte.
module boot_word_packer
    import kgp_boot_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [BYTE_BITS-1:0] byte_in,
    input  logic                 byte_valid,
    output logic                 word_last,
    output logic [WORD_BITS-1:0] word_out,
    output logic                 word_valid
);

    localparam int unsigned CNT_W   = $clog2(WORD_BYTES);
    localparam int unsigned SHIFT_W = WORD_BITS - BYTE_BITS;

    logic [CNT_W-1:0]   byte_cnt;
    logic [SHIFT_W-1:0] shift;

    // Combinational so the top can act on the final byte in its own handshake cycle.
    assign word_last = byte_valid && (byte_cnt == CNT_W'(WORD_BYTES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            byte_cnt   <= '0;
            shift      <= '0;
            word_out   <= '0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= word_last;
            if (byte_valid) begin
                byte_cnt <= byte_cnt + 1'b1;
                shift    <= {shift[SHIFT_W-BYTE_BITS-1:0], byte_in};
                if (word_last) begin
                    word_out <= {shift, byte_in};
                end
            end
        end
    end

endmodule

// File: rtl/imem_boot_loader.sv
// Receives a length-prefixed, XOR-checksummed program image and writes it into IMEM,
// holding the CPU in reset until a good image has been loaded.
module imem_boot_loader
    import kgp_boot_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 10,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_din,
    output logic                  cpu_rst,
    output logic                  done,
    output logic                  error
);

    localparam int unsigned MAX_WORDS = 32'd1 << ADDR_WIDTH;
    localparam int unsigned IDX_W     = ADDR_WIDTH + 1;

    boot_state_t      state;
    logic [7:0]       len_hi;
    logic [7:0]       csum;
    logic [IDX_W-1:0] word_count;
    logic [IDX_W-1:0] word_idx;
    logic [31:0]      idle_cnt;
    logic             accept;
    logic             data_byte;
    logic             word_last;
    logic             timed_out;
    logic [15:0]      len_word;

    assign accept    = rx_valid && rx_ready;
    assign data_byte = accept && (state == S_DATA);
    assign len_word  = {len_hi, rx_data};
    assign timed_out = (TIMEOUT_CYCLES != 0) && (idle_cnt == TIMEOUT_CYCLES - 1);

    boot_word_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .byte_in    (rx_data),
        .byte_valid (data_byte),
        .word_last  (word_last),
        .word_out   (imem_din),
        .word_valid (imem_we)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_LEN_HI;
            rx_ready   <= 1'b0;
            cpu_rst    <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
            imem_addr  <= '0;
            len_hi     <= '0;
            csum       <= '0;
            word_count <= '0;
            word_idx   <= '0;
            idle_cnt   <= '0;
        end else begin
            rx_ready <= 1'b1;
            if (accept || state == S_LEN_HI || state == S_DONE || state == S_ERROR) begin
                idle_cnt <= '0;
            end else begin
                idle_cnt <= idle_cnt + 1'b1;
            end

            case (state)
                S_LEN_HI: begin
                    if (accept) begin
                        len_hi <= rx_data;
                        state  <= S_LEN_LO;
                    end
                end
                S_LEN_LO: begin
                    if (accept) begin
                        if ({16'h0000, len_word} > MAX_WORDS) begin
                            state    <= S_ERROR;
                            error    <= 1'b1;
                            rx_ready <= 1'b0;
                        end else if (len_word == 16'h0000) begin
                            state <= S_CSUM;
                        end else begin
                            word_count <= IDX_W'(len_word);
                            state      <= S_DATA;
                        end
                    end else if (timed_out) begin
                        state    <= S_ERROR;
                        error    <= 1'b1;
                        rx_ready <= 1'b0;
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        csum <= csum ^ rx_data;
                        // The address is registered alongside the packer's word so both land together.
                        if (word_last) begin
                            imem_addr <= word_idx[ADDR_WIDTH-1:0];
                            word_idx  <= word_idx + 1'b1;
                            if (word_idx + 1'b1 == word_count) begin
                                state <= S_CSUM;
                            end
                        end
                    end else if (timed_out) begin
                        state    <= S_ERROR;
                        error    <= 1'b1;
                        rx_ready <= 1'b0;
                    end
                end
                S_CSUM: begin
                    if (accept) begin
                        rx_ready <= 1'b0;
                        if (rx_data == csum) begin
                            state   <= S_DONE;
                            done    <= 1'b1;
                            cpu_rst <= 1'b0;
                        end else begin
                            state <= S_ERROR;
                            error <= 1'b1;
                        end
                    end else if (timed_out) begin
                        state    <= S_ERROR;
                        error    <= 1'b1;
                        rx_ready <= 1'b0;
                    end
                end
                default: begin
                    rx_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule
